// File: rtl/tt_mux_pkg.sv
// Shared types and widths for the project multiplexer controller.
package tt_mux_pkg;
    localparam int IW_W   = 18;  // {uio_in, ui_in, rst_n, clk}
    localparam int OW_W   = 24;  // {uio_oe, uio_out, uo_out}
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        ACTIVE = 2'd2
    } mux_state_e;
endpackage

// File: rtl/tt_mux_sel_ctr.sv
// Project address counter: registered rising-edge detect on sel_inc,
// wrap at NUM_PROJ-1, sel_rst clears and wins over an increment edge.
module tt_mux_sel_ctr
    import tt_mux_pkg::*;
#(
    parameter int NUM_PROJ = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sel_rst,
    input  logic              i_sel_inc,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W-1:0] o_addr_nxt,
    output logic              o_chg
);
    logic              r_inc_d;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_edge;

    assign w_edge = i_sel_inc & ~r_inc_d;

    // Next address: clear beats increment; increment wraps so no value >= NUM_PROJ appears
    always_comb begin
        w_addr_nxt = r_addr;
        if (i_sel_rst)
            w_addr_nxt = '0;
        else if (w_edge)
            w_addr_nxt = (r_addr == ADDR_W'(NUM_PROJ - 1)) ? '0 : r_addr + 4'd1;
    end

    // Edge history and address register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inc_d <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_inc_d <= i_sel_inc;
            r_addr  <= w_addr_nxt;
        end
    end

    assign o_addr     = r_addr;
    assign o_addr_nxt = w_addr_nxt;
    assign o_chg      = (w_addr_nxt != r_addr);
endmodule

// File: rtl/tt_mux_ctrl.sv
// Project mux controller: break-before-make FSM plus registered pad muxing.
// All datapath registers are loaded from the next state, so enables and
// pads follow the ACTIVE state exactly, with no trailing cycle on exit.
module tt_mux_ctrl
    import tt_mux_pkg::*;
#(
    parameter int NUM_PROJ = 10,
    parameter int GAP      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sel_rst,
    input  logic                     sel_inc,
    input  logic                     ctrl_ena,
    input  logic [IW_W-1:0]          pad_in,
    output logic [OW_W-1:0]          pad_out,
    output logic [IW_W-1:0]          proj_iw,
    output logic [NUM_PROJ-1:0]      proj_ena,
    input  logic [NUM_PROJ*OW_W-1:0] proj_ow,
    output logic [ADDR_W-1:0]        cur_addr,
    output logic                     active
);
    mux_state_e          r_state, w_state_nxt;
    logic [2:0]          r_gap, w_gap_nxt;
    logic [ADDR_W-1:0]   w_addr, w_addr_nxt;
    logic                w_chg;
    logic [NUM_PROJ-1:0] w_ena_sel;
    logic [OW_W-1:0]     w_ow_sel;
    logic [NUM_PROJ-1:0] r_proj_ena;
    logic [IW_W-1:0]     r_proj_iw;
    logic [OW_W-1:0]     r_pad_out;

    tt_mux_sel_ctr #(.NUM_PROJ(NUM_PROJ)) u_sel_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_sel_rst  (sel_rst),
        .i_sel_inc  (sel_inc),
        .o_addr     (w_addr),
        .o_addr_nxt (w_addr_nxt),
        .o_chg      (w_chg)
    );

    // State and gap counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    // Next state: disable first, then address changes restart the gap
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        if (!ctrl_ena) begin
            w_state_nxt = IDLE;
            w_gap_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = SWITCH;
                    w_gap_nxt   = 3'(GAP);
                end
                SWITCH: begin
                    if (w_chg)
                        w_gap_nxt = 3'(GAP);
                    else if (r_gap <= 3'd1) begin
                        // counter reaches zero this cycle
                        w_state_nxt = ACTIVE;
                        w_gap_nxt   = '0;
                    end else
                        w_gap_nxt = r_gap - 3'd1;
                end
                ACTIVE: begin
                    if (w_chg) begin
                        w_state_nxt = SWITCH;
                        w_gap_nxt   = 3'(GAP);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_gap_nxt   = '0;
                end
            endcase
        end
    end

    // Decode the one-hot enable and output slice for the address in effect next cycle
    always_comb begin
        w_ena_sel = '0;
        w_ow_sel  = '0;
        for (int i = 0; i < NUM_PROJ; i++) begin
            if (w_addr_nxt == ADDR_W'(i)) begin
                w_ena_sel[i] = 1'b1;
                w_ow_sel     = proj_ow[i*OW_W +: OW_W];
            end
        end
    end

    // Registered datapath: everything zero unless next state is ACTIVE
    always_ff @(posedge clk) begin
        if (rst || w_state_nxt != ACTIVE) begin
            r_proj_ena <= '0;
            r_proj_iw  <= '0;
            r_pad_out  <= '0;
        end else begin
            r_proj_ena <= w_ena_sel;
            r_proj_iw  <= pad_in;
            r_pad_out  <= w_ow_sel;
        end
    end

    assign proj_ena = r_proj_ena;
    assign proj_iw  = r_proj_iw;
    assign pad_out  = r_pad_out;
    assign cur_addr = w_addr;
    assign active   = (r_state == ACTIVE);
endmodule

// File: doc/tt_mux_ctrl.md
TT_MUX_CTRL -- requirements
Module: tt_mux_ctrl

Interface
REQ-001 Parameter NUM_PROJ, default 10, number of project wrappers attached (2..16).
REQ-002 Parameter GAP, default 2, number of break-before-make cycles on project switch (1..7).
REQ-003 Port clk  input  1  single clock for all state.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port sel_rst  input  1  synchronous clear of project address.
REQ-006 Port sel_inc  input  1  address increment strobe; rising edge counts.
REQ-007 Port ctrl_ena  input  1  global enable of the selected project.
REQ-008 Port pad_in  input  18  packed pad word {uio_in, ui_in, rst_n, clk}.
REQ-009 Port pad_out  output  24  packed pad word {uio_oe, uio_out, uo_out}.
REQ-010 Port proj_iw  output  18  input word broadcast to all wrappers.
REQ-011 Port proj_ena  output  NUM_PROJ  one-hot wrapper enable.
REQ-012 Port proj_ow  input  NUM_PROJ*24  concatenated wrapper outputs; project i at bits [24*i+23:24*i].
REQ-013 Port cur_addr  output  4  current project address.
REQ-014 Port active  output  1  high in ACTIVE state.

Function
REQ-015 Address register SHALL increment by 1 on each cycle where sel_inc is 1 and was 0 the previous cycle (registered edge detect).
REQ-016 Address SHALL wrap from NUM_PROJ-1 to 0; values >= NUM_PROJ SHALL never occur.
REQ-017 sel_rst=1 SHALL force address to 0 next cycle, overriding a simultaneous sel_inc edge.
REQ-018 FSM states: IDLE, SWITCH, ACTIVE.
REQ-019 IDLE -> SWITCH when ctrl_ena=1; gap counter loads GAP.
REQ-020 SWITCH decrements gap counter each cycle; -> ACTIVE on the cycle the counter reaches 0 with ctrl_ena=1.
REQ-021 ACTIVE -> SWITCH (counter reloaded to GAP) on any address change, including sel_rst when address was nonzero.
REQ-022 Any state -> IDLE on ctrl_ena=0; this takes priority over address change.
REQ-023 Address change during SWITCH SHALL reload the gap counter to GAP.
REQ-024 proj_ena SHALL be registered: bit cur_addr set only in ACTIVE, all zero otherwise.
REQ-025 proj_iw SHALL be registered pad_in (latency 1) in ACTIVE, all zero otherwise (holds projects in reset, clk low).
REQ-026 pad_out SHALL be registered proj_ow slice for cur_addr (latency 1) in ACTIVE, all zero otherwise.
REQ-027 On transition out of ACTIVE, proj_ena, proj_iw and pad_out SHALL be zero from the next cycle.
REQ-028 No two proj_ena bits SHALL ever be high in the same cycle.

Reset
REQ-029 rst SHALL set state IDLE, address 0, gap counter 0, edge-detect history 0.
REQ-030 During and after reset all outputs SHALL be 0 (pad_out, proj_iw, proj_ena, cur_addr, active).
REQ-031 Reset mid-SWITCH or mid-ACTIVE SHALL abort to IDLE with no residual enable pulse.

Structure
REQ-032 Shared package tt_mux_pkg SHALL hold the state enum, IW_W=18, OW_W=24, ADDR_W=4.
REQ-033 One sub-module tt_mux_sel_ctr (edge detect, address counter, wrap) SHALL be instantiated; FSM and datapath muxing live in the top.

Verification
REQ-034 Reset release, ctrl_ena=1, pad_in=18'h3FFFF -> proj_ena=0 for GAP+1 cycles, then proj_ena=1, proj_iw=18'h3FFFF one cycle later.
REQ-035 ACTIVE at addr 0, 10 sel_inc pulses -> cur_addr passes 1..9 then wraps to 0; proj_ena zero for GAP cycles after each change.
REQ-036 sel_rst and sel_inc edge in same cycle at addr 5 -> cur_addr=0, FSM enters SWITCH.
REQ-037 ACTIVE at addr 3, proj_ow slice 3=24'hA5C3F0, other slices 24'hFFFFFF -> pad_out=24'hA5C3F0 one cycle later.
REQ-038 ctrl_ena dropped in ACTIVE -> next cycle proj_ena=0, proj_iw=0, pad_out=0, active=0.
REQ-039 rst asserted in SWITCH -> next cycle all outputs 0, state IDLE, no proj_ena pulse afterward.
